// File: rtl/bg_pkg.sv
// Shared types for the bank-group request buffer.
// Bank indices, bank names and a depth helper.
package bg_pkg;

    localparam int NUM_BANKS = 4;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        BANK_A,
        BANK_B,
        BANK_C,
        BANK_D
    } bank_e;

    function automatic int clog2_depth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bank_group_req_buffer_fifo.sv
// Per-bank request FIFO.
// Pointers wrap modulo DEPTH; count is one bit wider to tell full from empty.
module bank_req_fifo
    import bg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int AW = clog2_depth(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bank_group_req_buffer.sv
// Producer side of the bank-group drain handshake.
// Four bank FIFOs, head mux, and a burst cap that masks a bank for one cycle.
module bank_group_req_buffer
    import bg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_bank,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        valid,
    input  logic [3:0]        ready,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        full
);

    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    logic [NUM_BANKS-1:0] empty;
    logic [NUM_BANKS-1:0] push_vec;
    logic [NUM_BANKS-1:0] pop_vec;
    logic [NUM_BANKS-1:0] mask;
    logic [DATA_W-1:0]    head [NUM_BANKS];

    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] next_cnt;
    bank_idx_t     last_bank;
    bank_idx_t     pop_bank;
    logic          any_pop;
    logic          hit_cap;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vec[g]),
            .push_data (in_data),
            .pop       (pop_vec[g]),
            .head_data (head[g]),
            .empty     (empty[g]),
            .full      (full[g])
        );
    end

    assign in_ready = !full[in_bank];
    assign valid    = ~empty & ~mask;
    assign pop_vec  = valid & ready;
    assign out_data = head[sel];
    assign any_pop  = |pop_vec;

    // Steer an accepted request to its bank
    always_comb begin
        push_vec          = '0;
        push_vec[in_bank] = in_valid && in_ready;
    end

    // Identify the popping bank and the burst length it would reach
    always_comb begin
        pop_bank = BANK_A;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (pop_vec[b]) begin
                pop_bank = bank_idx_t'(b);
            end
        end
        next_cnt = (pop_bank == last_bank) ? burst_cnt + BW'(1) : BW'(1);
        hit_cap  = (MAX_BURST != 0) && (next_cnt == BW'(MAX_BURST));
    end

    // Burst counter and one-cycle mask of the bank that hit the cap
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
            last_bank <= BANK_A;
            mask      <= '0;
        end else begin
            mask <= '0;
            if (!any_pop) begin
                burst_cnt <= '0;
            end else begin
                last_bank <= pop_bank;
                if (hit_cap) begin
                    mask[pop_bank] <= 1'b1;
                    burst_cnt      <= '0;
                end else begin
                    burst_cnt <= next_cnt;
                end
            end
        end
    end

    // Drain FSM must pop at most one bank per cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(ready));
        end
    end

endmodule
